// File: rtl/core_v_mcu_pkg.sv
// Shared peripheral-bus types and constants: reg-bus request/response
// structs, address rules, the default peripheral map and demux defaults.
package core_v_mcu_pkg;

    localparam int unsigned RegAddrWidth = 64;
    localparam int unsigned RegDataWidth = 32;
    localparam int unsigned RegStrbWidth = RegDataWidth / 8;

    typedef struct packed {
        logic [RegAddrWidth-1:0] addr;
        logic                    write;
        logic [RegDataWidth-1:0] wdata;
        logic [RegStrbWidth-1:0] wstrb;
        logic                    valid;
    } reg_req_t;

    typedef struct packed {
        logic [RegDataWidth-1:0] rdata;
        logic                    error;
        logic                    ready;
    } reg_rsp_t;

    // Address rule: start inclusive, end exclusive.
    typedef struct packed {
        logic [RegAddrWidth-1:0] start_addr;
        logic [RegAddrWidth-1:0] end_addr;
    } rule_t;

    typedef enum logic [1:0] {
        StIdle,
        StFwd,
        StErr
    } demux_state_e;

    localparam int unsigned PeriphNumSlaves = 4;
    localparam int unsigned PeriphIdxUart   = 0;
    localparam int unsigned PeriphIdxGpio   = 1;
    localparam int unsigned PeriphIdxTimer  = 2;
    localparam int unsigned PeriphIdxDebug  = 3;

    // The debug window deliberately overlaps the upper half of the timer
    // window; the timer (lower index) owns the shared range while enabled.
    localparam rule_t [PeriphNumSlaves-1:0] PeriphRegMap = '{
        PeriphIdxUart:  '{start_addr: 64'h1000_0000_0000_0000, end_addr: 64'h1000_1000_0000_0000},
        PeriphIdxGpio:  '{start_addr: 64'h1000_1000_0000_0000, end_addr: 64'h1000_2000_0000_0000},
        PeriphIdxTimer: '{start_addr: 64'h1000_2000_0000_0000, end_addr: 64'h1000_3000_0000_0000},
        PeriphIdxDebug: '{start_addr: 64'h1000_2800_0000_0000, end_addr: 64'h1000_4000_0000_0000}
    };

    localparam logic [RegDataWidth-1:0] RegErrData        = 32'hBADC_AB1E;
    localparam int unsigned             RegTimeoutDefault = 1024;

endpackage

// File: rtl/reg_addr_decode.sv
// Combinational address decoder: matches an address against a rule table,
// gated by per-rule enables, and resolves overlaps to the lowest index.
module reg_addr_decode
    import core_v_mcu_pkg::*;
#(
    parameter int unsigned NumRules = 4,
    parameter int unsigned SelWidth = (NumRules > 1) ? $clog2(NumRules) : 1
) (
    input  logic [RegAddrWidth-1:0] addr,
    input  rule_t [NumRules-1:0]    rules,
    input  logic [NumRules-1:0]     enable,
    output logic [NumRules-1:0]     hit_onehot,
    output logic [SelWidth-1:0]     sel,
    output logic                    miss
);

    logic [NumRules-1:0] hit;

    // Raw per-rule match, possibly several bits set when rules overlap.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NumRules; i++) begin
            hit[i] = enable[i] && (addr >= rules[i].start_addr) && (addr < rules[i].end_addr);
        end
    end

    // Priority pick: scanning downwards leaves the lowest matching index.
    always_comb begin
        hit_onehot = '0;
        sel        = '0;
        for (int i = NumRules - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_onehot    = '0;
                hit_onehot[i] = 1'b1;
                sel           = SelWidth'(i);
            end
        end
    end

    assign miss = ~|hit;

endmodule

// File: rtl/reg_periph_demux.sv
// Reg-bus peripheral demultiplexer: fans one master out to NumSlaves slaves,
// answers decode misses and hung slaves with an error response, and records
// the cause/address of the last error plus a saturating timeout count.
module reg_periph_demux
    import core_v_mcu_pkg::*;
#(
    parameter int unsigned          NumSlaves     = PeriphNumSlaves,
    parameter int unsigned          AddrWidth     = RegAddrWidth,
    parameter int unsigned          DataWidth     = RegDataWidth,
    parameter int unsigned          TimeoutCycles = RegTimeoutDefault,
    parameter rule_t [NumSlaves-1:0] RegMap       = PeriphRegMap,
    parameter logic [DataWidth-1:0] ErrData       = RegErrData
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NumSlaves-1:0]     slave_en_i,
    input  reg_req_t                 mst_req_i,
    output reg_rsp_t                 mst_rsp_o,
    output reg_req_t [NumSlaves-1:0] slv_req_o,
    input  reg_rsp_t [NumSlaves-1:0] slv_rsp_i,
    output logic                     err_pulse_o,
    output logic                     err_timeout_o,
    output logic [AddrWidth-1:0]     err_addr_o,
    output logic [15:0]              timeout_cnt_o
);

    localparam int unsigned SelWidth = (NumSlaves > 1) ? $clog2(NumSlaves) : 1;

    demux_state_e         state_q, state_d;
    logic [SelWidth-1:0]  sel_q, dec_sel;
    logic [NumSlaves-1:0] sel_onehot_q, dec_onehot;
    logic                 dec_miss;
    logic                 slv_ready;
    logic                 wd_expire;
    logic                 timeout_evt;

    reg_addr_decode #(
        .NumRules (NumSlaves),
        .SelWidth (SelWidth)
    ) u_decode (
        .addr       (mst_req_i.addr),
        .rules      (RegMap),
        .enable     (slave_en_i),
        .hit_onehot (dec_onehot),
        .sel        (dec_sel),
        .miss       (dec_miss)
    );

    assign slv_ready   = slv_rsp_i[sel_q].ready;
    assign timeout_evt = (state_q == StFwd) && !slv_ready && wd_expire;

    // Watchdog only exists when a timeout is configured; it restarts in IDLE.
    if (TimeoutCycles != 0) begin : g_watchdog
        localparam int unsigned WdWidth = $clog2(TimeoutCycles + 1);
        logic [WdWidth-1:0] wd_q;

        // Count FWD cycles spent waiting on the selected slave.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                wd_q <= '0;
            end else if (state_q == StIdle) begin
                wd_q <= '0;
            end else if ((state_q == StFwd) && !slv_ready) begin
                wd_q <= wd_q + 1'b1;
            end
        end

        assign wd_expire = (wd_q == WdWidth'(TimeoutCycles - 1));
    end else begin : g_no_watchdog
        assign wd_expire = 1'b0;
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a slave ready beats a simultaneous watchdog expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (mst_req_i.valid) begin
                    state_d = dec_miss ? StErr : StFwd;
                end
            end
            StFwd: begin
                if (slv_ready) begin
                    state_d = StIdle;
                end else if (wd_expire) begin
                    state_d = StErr;
                end
            end
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic: route the request to the selected slave and mirror its
    // response, or return the canned error response for one cycle.
    always_comb begin
        mst_rsp_o   = '0;
        err_pulse_o = 1'b0;
        for (int i = 0; i < NumSlaves; i++) begin
            slv_req_o[i]       = mst_req_i;
            slv_req_o[i].valid = (state_q == StFwd) && sel_onehot_q[i];
        end
        case (state_q)
            StFwd: mst_rsp_o = slv_rsp_i[sel_q];
            StErr: begin
                mst_rsp_o.rdata = RegDataWidth'(ErrData);
                mst_rsp_o.error = 1'b1;
                mst_rsp_o.ready = 1'b1;
                err_pulse_o     = 1'b1;
            end
            default: ;
        endcase
    end

    // Slave selection is captured once in IDLE so enable changes mid-flight
    // cannot redirect or abort the transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_q        <= '0;
            sel_onehot_q <= '0;
        end else if ((state_q == StIdle) && mst_req_i.valid && !dec_miss) begin
            sel_q        <= dec_sel;
            sel_onehot_q <= dec_onehot;
        end
    end

    // Error capture on entry to ERR so the values are visible with the pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_timeout_o <= 1'b0;
            err_addr_o    <= '0;
            timeout_cnt_o <= '0;
        end else if ((state_q == StIdle) && mst_req_i.valid && dec_miss) begin
            err_timeout_o <= 1'b0;
            err_addr_o    <= AddrWidth'(mst_req_i.addr);
        end else if (timeout_evt) begin
            err_timeout_o <= 1'b1;
            err_addr_o    <= AddrWidth'(mst_req_i.addr);
            if (timeout_cnt_o != 16'hFFFF) begin
                timeout_cnt_o <= timeout_cnt_o + 16'd1;
            end
        end
    end

endmodule
